// File: rtl/hpdmc_fml_arb.sv
// hpdmc_fml_arb - N-port FML arbiter in front of the HPDMC FML slave port.
//
// Grants one of NPORTS FML masters at a time. The policy is round-robin or
// fixed priority, where the lowest index wins. The address phase of the next
// transfer overlaps the data burst of the current one. Write data and byte
// selects are steered from the master that owns the running burst.
//
// Ports
//   sys_clk, sys_rst_n        clock (rising edge), async active-low reset
//   m_adr/m_stb/m_we          per-master request (port i at slice i)
//   m_sel/m_di                per-master byte selects / write data, per beat
//   m_ack                     one-hot acknowledge pulse to the granted master
//   m_do                      read data, broadcast to all masters
//   s_adr/s_stb/s_we/s_ack    address phase towards the controller
//   s_sel/s_di/s_do           data phase towards/from the controller
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | no request presented; pick a winner once the data bus frees up
// ST_REQ  | winner's address on s_*, s_stb gated until the last data beat
module hpdmc_fml_arb #(
  parameter int NPORTS    = 4,
  parameter int ADR_W     = 26,
  parameter int DATA_W    = 64,
  parameter int BURST     = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [NPORTS*ADR_W-1:0]    m_adr,
  input  logic [NPORTS-1:0]          m_stb,
  input  logic [NPORTS-1:0]          m_we,
  output logic [NPORTS-1:0]          m_ack,
  input  logic [NPORTS*DATA_W/8-1:0] m_sel,
  input  logic [NPORTS*DATA_W-1:0]   m_di,
  output logic [DATA_W-1:0]          m_do,
  output logic [ADR_W-1:0]           s_adr,
  output logic                       s_stb,
  output logic                       s_we,
  input  logic                       s_ack,
  output logic [DATA_W/8-1:0]        s_sel,
  output logic [DATA_W-1:0]          s_di,
  input  logic [DATA_W-1:0]          s_do
);

  localparam int GW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CW = $clog2(BURST + 1);
  localparam int SW = DATA_W / 8;
  localparam logic [GW-1:0] LAST_PORT = GW'(NPORTS - 1);
  localparam logic [CW-1:0] BURST_C   = CW'(BURST);

  typedef enum logic {ST_IDLE, ST_REQ} state_t;

  state_t         r_state, w_state_nxt;
  logic [GW-1:0]  r_gnt, r_dport, r_last, w_win;
  logic [CW-1:0]  r_dcnt;
  logic           r_dwe;
  logic           w_any, w_take, w_gnt_stb, w_slot_free, w_addr_free;

  // Round-robin: first requester after the last grant, wrapping modulo NPORTS.
  // Scanning from the far end backwards lets the nearest requester win.
  function automatic logic [GW-1:0] rr_pick(input logic [NPORTS-1:0] req,
                                            input logic [GW-1:0]     last);
    logic [GW-1:0] pick;
    logic [GW-1:0] idx_c;
    int            idx;
    pick = '0;
    for (int k = NPORTS; k >= 1; k--) begin
      idx   = (int'(last) + k) % NPORTS;
      idx_c = GW'(idx);
      if (req[idx_c]) pick = idx_c;
    end
    return pick;
  endfunction

  function automatic logic [GW-1:0] prio_pick(input logic [NPORTS-1:0] req);
    logic [GW-1:0] pick;
    pick = '0;
    for (int i = NPORTS - 1; i >= 0; i--) begin
      if (req[i]) pick = GW'(i);
    end
    return pick;
  endfunction

  assign w_any       = |m_stb;
  assign w_win       = (PRIO_MODE != 0) ? prio_pick(m_stb) : rr_pick(m_stb, r_last);
  assign w_gnt_stb   = m_stb[r_gnt];
  assign w_slot_free = (r_dcnt <= CW'(1));
  // The grant is taken one cycle early (two beats left). This puts the
  // address phase in ST_REQ on the last beat, so a back-to-back burst has no gap.
  assign w_addr_free = (r_dcnt <= CW'(2));

  always_comb begin
    w_state_nxt = r_state;
    s_stb       = 1'b0;
    s_we        = 1'b0;
    s_adr       = '0;
    m_ack       = '0;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any && w_addr_free) w_state_nxt = ST_REQ;
      end
      ST_REQ: begin
        s_adr = m_adr[int'(r_gnt)*ADR_W +: ADR_W];
        s_we  = m_we[r_gnt];
        s_stb = w_gnt_stb & w_slot_free;
        if (s_stb && s_ack) begin
          m_ack[r_gnt] = 1'b1;
          w_take       = 1'b1;
          w_state_nxt  = ST_IDLE;
        end else if (!w_gnt_stb) begin
          // master withdrew its request before the ack: give up the grant
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_gnt   <= '0;
      r_dport <= '0;
      r_dwe   <= 1'b0;
      r_dcnt  <= '0;
      r_last  <= LAST_PORT;
    end else begin
      if (r_state == ST_IDLE && w_state_nxt == ST_REQ) r_gnt <= w_win;
      if (w_take) begin
        r_dport <= r_gnt;
        r_dwe   <= s_we;
        r_dcnt  <= BURST_C;
        r_last  <= r_gnt;
      end else if (r_dcnt != '0) begin
        r_dcnt <= r_dcnt - CW'(1);
      end
    end
  end

  assign s_sel = (r_dcnt != '0 && r_dwe) ? m_sel[int'(r_dport)*SW +: SW] : '0;
  assign s_di  = (r_dcnt != '0 && r_dwe) ? m_di[int'(r_dport)*DATA_W +: DATA_W] : '0;
  assign m_do  = s_do;

endmodule
